// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM stage. Duty triples are double-buffered and each channel
// commits its new duty only on its own period boundary, so pulses are never cut short.
module rgb_pwm_driver #(
  parameter int unsigned PWM_INTERVAL  = 1200,
  parameter bit          PHASE_STAGGER = 1'b1,
  parameter bit          ACTIVE_LOW    = 1'b1,
  localparam int unsigned W = $clog2(PWM_INTERVAL + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] duty_r,
  input  logic [W-1:0] duty_g,
  input  logic [W-1:0] duty_b,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         led_r,
  output logic         led_g,
  output logic         led_b,
  output logic         period_start
);

  localparam int unsigned STEP = PHASE_STAGGER ? PWM_INTERVAL / 3 : 0;
  localparam logic [W-1:0] LP_LAST = W'(PWM_INTERVAL - 1);
  localparam logic [W-1:0] LP_MAX  = W'(PWM_INTERVAL);
  // Channel counters start at (0 - phase_k) mod PWM_INTERVAL so they track cnt with a fixed lag.
  localparam logic [2:0][W-1:0] LP_CH_INIT = {
    W'((PWM_INTERVAL - 2 * STEP) % PWM_INTERVAL),
    W'((PWM_INTERVAL - STEP) % PWM_INTERVAL),
    W'(0)
  };

  logic [W-1:0]      r_cnt;
  logic [2:0][W-1:0] r_ch;
  logic [2:0][W-1:0] r_active;
  logic [2:0][W-1:0] r_shadow;
  logic [2:0]        r_pending;
  logic [2:0]        r_on;
  logic              r_period_start;
  logic              r_rst_q;

  logic [2:0][W-1:0] w_duty_in;
  logic [2:0][W-1:0] w_duty_clamped;
  logic              w_xfer;

  always_comb begin
    w_duty_in      = {duty_b, duty_g, duty_r};
    w_duty_clamped = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_duty_clamped[k] = (w_duty_in[k] > LP_MAX) ? LP_MAX : w_duty_in[k];
    end
  end

  assign duty_ready = r_rst_q && (r_pending == 3'b000);
  assign w_xfer     = duty_valid && duty_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_ch           <= LP_CH_INIT;
      r_active       <= '0;
      r_shadow       <= '0;
      r_pending      <= '0;
      r_on           <= '0;
      r_period_start <= 1'b0;
      r_rst_q        <= 1'b0;
    end else begin
      r_rst_q        <= 1'b1;
      r_period_start <= (r_cnt == '0);
      r_cnt          <= (r_cnt == LP_LAST) ? '0 : r_cnt + W'(1);
      for (int unsigned k = 0; k < 3; k++) begin
        r_ch[k] <= (r_ch[k] == LP_LAST) ? '0 : r_ch[k] + W'(1);
        r_on[k] <= (r_ch[k] < r_active[k]);
        // Commit on the last cycle of the channel period; the new duty first shows at ch == 0.
        if ((r_ch[k] == LP_LAST) && r_pending[k]) begin
          r_active[k]  <= r_shadow[k];
          r_pending[k] <= 1'b0;
        end
      end
      // A transfer needs pending == 0, so it never coincides with a commit.
      if (w_xfer) begin
        r_shadow  <= w_duty_clamped;
        r_pending <= '1;
      end
    end
  end

  assign led_r        = r_on[0] ^ ACTIVE_LOW;
  assign led_g        = r_on[1] ^ ACTIVE_LOW;
  assign led_b        = r_on[2] ^ ACTIVE_LOW;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench: in-phase instance (dut0) and staggered instance (dut1), PWM_INTERVAL = 12.
module tb_rgb_pwm_driver;

  localparam int unsigned N = 12;
  localparam int unsigned W = $clog2(N + 1);

  logic clk;
  logic rst_n;
  logic [W-1:0] d0_r, d0_g, d0_b, d1_r, d1_g, d1_b;
  logic v0, v1;
  logic ready0, ready1;
  logic led0_r, led0_g, led0_b, led1_r, led1_g, led1_b;
  logic ps0, ps1;

  int checks = 0;
  int errors = 0;

  rgb_pwm_driver #(.PWM_INTERVAL(N), .PHASE_STAGGER(1'b0), .ACTIVE_LOW(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .duty_r(d0_r), .duty_g(d0_g), .duty_b(d0_b),
    .duty_valid(v0), .duty_ready(ready0), .led_r(led0_r), .led_g(led0_g), .led_b(led0_b),
    .period_start(ps0)
  );

  rgb_pwm_driver #(.PWM_INTERVAL(N), .PHASE_STAGGER(1'b1), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .duty_r(d1_r), .duty_g(d1_g), .duty_b(d1_b),
    .duty_valid(v1), .duty_ready(ready1), .led_r(led1_r), .led_g(led1_g), .led_b(led1_b),
    .period_start(ps1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r, g, b;
    logic [11:0]  er, eg, eb;   // bit i set = LED on (pin low) in cycle i of the period
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input bit d);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ((d ? ready1 : ready0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("timeout_ready", 0, 1);
  endtask

  task automatic wait_ps(input bit d);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((d ? ps1 : ps0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("timeout_period_start", 0, 1);
  endtask

  task automatic send(input bit d, input logic [W-1:0] r, input logic [W-1:0] g,
                      input logic [W-1:0] b);
    wait_ready(d);
    if (d) begin d1_r = r; d1_g = g; d1_b = b; v1 = 1'b1; end
    else   begin d0_r = r; d0_g = g; d0_b = b; v0 = 1'b1; end
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Samples 12 cycles starting at the current negedge; optionally drives a red-only write at cycle wr_at.
  task automatic capture(input bit d, input int wr_at, input logic [W-1:0] wr_r,
                         output logic [11:0] mr, output logic [11:0] mg,
                         output logic [11:0] mb, output int overlap);
    overlap = 0;
    for (int i = 0; i < 12; i++) begin
      mr[i] = d ? ~led1_r : ~led0_r;
      mg[i] = d ? ~led1_g : ~led0_g;
      mb[i] = d ? ~led1_b : ~led0_b;
      if ((int'(mr[i]) + int'(mg[i]) + int'(mb[i])) > 1) overlap++;
      if (i == wr_at) begin
        if (d) begin d1_r = wr_r; v1 = 1'b1; end
        else   begin d0_r = wr_r; v0 = 1'b1; end
      end else begin
        v0 = 1'b0;
        v1 = 1'b0;
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic check_masks(input string tag, input logic [11:0] mr, input logic [11:0] mg,
                             input logic [11:0] mb, input logic [11:0] er,
                             input logic [11:0] eg, input logic [11:0] eb);
    check({tag, "_r"}, 32'(mr), 32'(er));
    check({tag, "_g"}, 32'(mg), 32'(eg));
    check({tag, "_b"}, 32'(mb), 32'(eb));
  endtask

  initial begin
    vec_t vecs[4];
    logic [11:0] mr, mg, mb;
    int ov;
    int held;

    vecs[0] = '{r: 4'd3,  g: 4'd6,  b: 4'd12, er: 12'h007, eg: 12'h03F, eb: 12'hFFF};
    vecs[1] = '{r: 4'd0,  g: 4'd1,  b: 4'd11, er: 12'h000, eg: 12'h001, eb: 12'h7FF};
    vecs[2] = '{r: 4'd15, g: 4'd13, b: 4'd8,  er: 12'hFFF, eg: 12'hFFF, eb: 12'h0FF};
    vecs[3] = '{r: 4'd8,  g: 4'd2,  b: 4'd4,  er: 12'h0FF, eg: 12'h003, eb: 12'h00F};

    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    d0_r = '0; d0_g = '0; d0_b = '0;
    d1_r = '0; d1_g = '0; d1_b = '0;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_led_r", 32'(led0_r), 1);
    check("rst_led_g", 32'(led0_g), 1);
    check("rst_led_b", 32'(led0_b), 1);
    check("rst_period_start", 32'(ps0), 0);
    check("rst_ready", 32'(ready0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(ready0), 1);
    for (int j = 0; j < 25; j++) begin
      check($sformatf("ps_cadence_%0d", j), 32'(ps0), (j % 12 == 0) ? 1 : 0);
      @(negedge clk);
    end

    // In-phase widths and clamping
    for (int i = 0; i < 4; i++) begin
      send(1'b0, vecs[i].r, vecs[i].g, vecs[i].b);
      wait_ready(1'b0);
      wait_ps(1'b0);
      capture(1'b0, -1, '0, mr, mg, mb, ov);
      check_masks($sformatf("vec%0d", i), mr, mg, mb, vecs[i].er, vecs[i].eg, vecs[i].eb);
    end

    // Glitch-free update: red 8 active, write 2 during cnt == 3 (cycle index 2)
    capture(1'b0, 2, 4'd2, mr, mg, mb, ov);
    check("glitch_cur_r", 32'(mr), 32'h0FF);
    capture(1'b0, -1, '0, mr, mg, mb, ov);
    check_masks("glitch_next", mr, mg, mb, 12'h003, 12'h003, 12'h00F);

    // Write on cnt == 11 (cycle index 10) lands one full period later
    capture(1'b0, 10, 4'd7, mr, mg, mb, ov);
    check("late_wr_p0_r", 32'(mr), 32'h003);
    check("late_wr_ready_low", 32'(ready0), 0);
    capture(1'b0, -1, '0, mr, mg, mb, ov);
    check("late_wr_p1_r", 32'(mr), 32'h003);
    capture(1'b0, -1, '0, mr, mg, mb, ov);
    check("late_wr_p2_r", 32'(mr), 32'h07F);

    // Backpressure: held oversize triple is taken only after 5/5/5 fully commits
    send(1'b0, 4'd5, 4'd5, 4'd5);
    d0_r = 4'd15;
    v0 = 1'b1;
    check("bp_ready_low", 32'(ready0), 0);
    held = 0;
    while (ready0 !== 1'b1 && held < 40) begin
      held++;
      @(negedge clk);
    end
    check("bp_ready_timeout", (held < 40) ? 1 : 0, 1);
    @(negedge clk);
    v0 = 1'b0;
    check("bp_ready_before_ps", 32'(ps0), 1);
    capture(1'b0, -1, '0, mr, mg, mb, ov);
    check_masks("bp_first", mr, mg, mb, 12'h01F, 12'h01F, 12'h01F);
    capture(1'b0, -1, '0, mr, mg, mb, ov);
    check_masks("bp_held", mr, mg, mb, 12'hFFF, 12'h01F, 12'h01F);

    // Reset mid-period with duty 6 active and 9 pending
    send(1'b0, 4'd6, 4'd6, 4'd6);
    wait_ready(1'b0);
    wait_ps(1'b0);
    d0_r = 4'd9; d0_g = 4'd9; d0_b = 4'd9;
    v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    check("midrst_led_on", 32'(led0_r), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_led_r", 32'(led0_r), 1);
    check("midrst_led_g", 32'(led0_g), 1);
    check("midrst_led_b", 32'(led0_b), 1);
    check("midrst_ready", 32'(ready0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", 32'(ready0), 1);
    check("midrst_ps_after", 32'(ps0), 1);
    capture(1'b0, -1, '0, mr, mg, mb, ov);
    check_masks("midrst_p0", mr, mg, mb, 12'h000, 12'h000, 12'h000);
    capture(1'b0, -1, '0, mr, mg, mb, ov);
    check_masks("midrst_p1", mr, mg, mb, 12'h000, 12'h000, 12'h000);

    // Staggered instance, 4/4/4
    send(1'b1, 4'd4, 4'd4, 4'd4);
    wait_ready(1'b1);
    wait_ps(1'b1);
    capture(1'b1, -1, '0, mr, mg, mb, ov);
    check_masks("stagger", mr, mg, mb, 12'h00F, 12'h0F0, 12'hF00);
    check("stagger_overlap", 32'(ov), 0);
    capture(1'b1, -1, '0, mr, mg, mb, ov);
    check_masks("stagger2", mr, mg, mb, 12'h00F, 12'h0F0, 12'hF00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
